// File: rtl/hi_lo_muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizes for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hi_lo_muldiv_if.sv
// hi_lo_muldiv_if: operand/command/result bundle between pipeline and HI/LO unit.
// Latency: n/a (wires only).
// Backpressure: busy from the slave stalls the master's MFHI/MFLO/muldiv issue.
interface hi_lo_muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             mthiEn;
  logic             mtloEn;
  logic [WIDTH-1:0] mtData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opA, opB, mthiEn, mtloEn, mtData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, mthiEn, mtloEn, mtData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hi_lo_muldiv_iter_core.sv
// muldiv_iter_core: 2*WIDTH working register doing one radix-2 mul or div step per cycle.
// Latency: step_res is combinational from the register; the register advances on each step edge.
// Backpressure: none; the parent FSM sequences load/step.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   init_lo,
  input  logic [WIDTH-1:0]   init_opnd,
  output logic [2*WIDTH-1:0] step_res
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     rem_sh, diff, sum;

  // One step: shift-right/add for multiply, shift-left/trial-subtract for divide.
  always_comb begin
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    if (is_div) begin
      // diff MSB clear means the trial subtract did not borrow: keep it, quotient bit 1.
      if (!diff[WIDTH]) step_res = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              step_res = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_res = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Working register next-state: load seeds {0, x}, step applies one iteration.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, init_lo};
      opnd_d = init_opnd;
    end else if (step) begin
      acc_d = step_res;
    end
  end

  // Working register state.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes.
// Latency: WIDTH+1 cycles start-to-done (1 cycle for zero operands with MULDIV_FAST_ZERO_EN).
// Backpressure: busy stalls the pipeline; start during busy is dropped; start beats MTHI/MTLO.
module hi_lo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clock,
  input logic            reset,
  hi_lo_muldiv_if.slave  bus
);

  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               op_is_div, op_signed, a_neg, b_neg;
  logic               accept, fast_zero, core_load, core_step;
  logic [WIDTH-1:0]   a_mag, b_mag, init_lo, init_opnd;
  logic [2*WIDTH-1:0] step_res, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Operand decode: magnitudes for signed ops; the core always works unsigned.
  always_comb begin
    op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = op_signed & bus.opA[WIDTH-1];
    b_neg     = op_signed & bus.opB[WIDTH-1];
    a_mag     = a_neg ? -bus.opA : bus.opA;
    b_mag     = b_neg ? -bus.opB : bus.opB;
    accept    = bus.start && (state_q != S_BUSY);
`ifdef MULDIV_FAST_ZERO_EN
    fast_zero = (bus.opA == '0) || (bus.opB == '0);
`else
    fast_zero = 1'b0;
`endif
    core_load = accept && !fast_zero;
    core_step = (state_q == S_BUSY);
    init_lo   = op_is_div ? a_mag : b_mag;
    init_opnd = op_is_div ? b_mag : a_mag;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (core_load),
    .step      (core_step),
    .is_div    (is_div_q),
    .init_lo   (init_lo),
    .init_opnd (init_opnd),
    .step_res  (step_res)
  );

  // Sign fix-up of the final step; remainder follows the dividend, div-by-zero forces all-ones.
  always_comb begin
    prod_fix = neg_q ? -step_res : step_res;
    quot_fix = div0_q ? '1 : (neg_q ? -step_res[WIDTH-1:0] : step_res[WIDTH-1:0]);
    rem_fix  = rem_neg_q ? -step_res[2*WIDTH-1:WIDTH] : step_res[2*WIDTH-1:WIDTH];
  end

  // FSM next-state, HI/LO update and MTHI/MTLO writes (IDLE and DONE behave alike).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_BUSY: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          is_div_d  = op_is_div;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (bus.opB == '0);
          cnt_d     = '0;
          if (fast_zero) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (op_is_div && (bus.opB == '0)) begin
              hi_d = bus.opA;
              lo_d = '1;
            end else begin
              hi_d = '0;
              lo_d = '0;
            end
          end else begin
            state_d = S_BUSY;
            busy_d  = 1'b1;
          end
        end else begin
          if (bus.mthiEn) hi_d = bus.mtData;
          if (bus.mtloEn) lo_d = bus.mtData;
        end
      end
    endcase
  end

  // FSM and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// tb_hi_lo_muldiv: directed vector table, hand sequences and random ops against an arithmetic model.
// Latency: checks WIDTH+1 start-to-done and busy width on every operation.
// Backpressure: pokes start/MTHI/MTLO during busy and expects them to be dropped.
module tb_hi_lo_muldiv;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  hi_lo_muldiv_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit fast_zero(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    return (a == 32'd0) || (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain two's-complement / unsigned arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] up;
    int ia, ib, q, r;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        return sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        ia = a;
        ib = b;
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op at the current negedge and follow it to done, checking latency, busy and HI/LO hold.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int poke_cycle,
                        input bit poke_start, input bit poke_mt, input bit launch_mt);
    logic [31:0] pre_hi, pre_lo;
    int lat, bcnt;
    bit hold_ok, fast;
    fast = fast_zero(a, b);
    pre_hi = bus.hi;
    pre_lo = bus.lo;
    bus.start = 1'b1;
    bus.op = op;
    bus.opA = a;
    bus.opB = b;
    bus.mthiEn = launch_mt;
    bus.mtloEn = launch_mt;
    bus.mtData = 32'h5A5A_1234;
    @(negedge clock);
    bus.start = 1'b0;
    bus.mthiEn = 1'b0;
    bus.mtloEn = 1'b0;
    bus.op = 2'($urandom);
    bus.opA = $urandom;
    bus.opB = $urandom;
    lat = 0;
    bcnt = 0;
    hold_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) bcnt++;
      if (bus.hi !== pre_hi || bus.lo !== pre_lo) hold_ok = 1'b0;
      if (n == poke_cycle) begin
        bus.start = poke_start;
        bus.mthiEn = poke_mt;
        bus.mtloEn = poke_mt;
        bus.mtData = $urandom;
        bus.op = 2'($urandom);
        bus.opA = $urandom;
        bus.opB = $urandom;
      end else begin
        bus.start = 1'b0;
        bus.mthiEn = 1'b0;
        bus.mtloEn = 1'b0;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.mthiEn = 1'b0;
    bus.mtloEn = 1'b0;
    chk({name, " latency"}, 64'(lat), fast ? 64'd1 : 64'd33);
    chk({name, " busy_cycles"}, 64'(bcnt), fast ? 64'd0 : 64'd32);
    chk({name, " hilo_hold"}, 64'(hold_ok), 64'd1);
    chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    bit seen;

    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.opA = '0;
    bus.opB = '0;
    bus.mthiEn = 1'b0;
    bus.mtloEn = 1'b0;
    bus.mtData = '0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{2'b00, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{2'b10, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed vectors, launched back-to-back from the DONE cycle.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 0, 1'b0, 1'b0, 1'b0);
    end

    // Start pulsed mid-operation is dropped: same result, one done, then idle.
    @(negedge clock);
    run_op("ign_start", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           10, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("ign_start single_done", 64'(bus.done), 64'd0);
    chk("ign_start idle_busy", 64'(bus.busy), 64'd0);

    // MTHI in IDLE, then both enables together.
    bus.mthiEn = 1'b1;
    bus.mtData = 32'hAAAA_0000;
    @(negedge clock);
    bus.mthiEn = 1'b0;
    chk("mthi hi", 64'(bus.hi), 64'h0000_0000_AAAA_0000);
    chk("mthi lo_kept", 64'(bus.lo), 64'h0000_0000_0000_0001);
    bus.mthiEn = 1'b1;
    bus.mtloEn = 1'b1;
    bus.mtData = 32'h1357_9BDF;
    @(negedge clock);
    bus.mthiEn = 1'b0;
    bus.mtloEn = 1'b0;
    chk("mtboth hi", 64'(bus.hi), 64'h0000_0000_1357_9BDF);
    chk("mtboth lo", 64'(bus.lo), 64'h0000_0000_1357_9BDF);

    // Start wins over MTHI/MTLO on the same edge; MTHI in DONE is honoured.
    run_op("start_wins", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0, 1'b0, 1'b1);
    bus.mthiEn = 1'b1;
    bus.mtData = 32'hCAFE_0001;
    @(negedge clock);
    bus.mthiEn = 1'b0;
    chk("mthi_in_done hi", 64'(bus.hi), 64'h0000_0000_CAFE_0001);

    // MTHI/MTLO during BUSY are dropped.
    run_op("mt_busy", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 1'b1, 1'b0);

    // Random ops against the arithmetic model, with random gaps and mid-op pokes.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra = pick();
      rb = pick();
      rexp = model(rop, ra, rb);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
      run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, rexp[63:32], rexp[31:0],
             int'($urandom_range(1, 31)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in cycle 10 of a MULT aborts it with no later done.
    @(negedge clock);
    bus.mthiEn = 1'b1;
    bus.mtloEn = 1'b1;
    bus.mtData = 32'h1357_9BDF;
    @(negedge clock);
    bus.mthiEn = 1'b0;
    bus.mtloEn = 1'b0;
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.opA = 32'h0000_1234;
    bus.opB = 32'h0000_5678;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) seen = 1'b1;
      @(negedge clock);
    end
    chk("abort no_done", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
